// File: rtl/moore_det_pkg.sv
// Shared constants and helpers for the Moore sequence detector.
// Also used by the optional inactivity timeout (MOORE_DET_TIMEOUT_EN).
package moore_det_pkg;

    localparam int DEF_SYM_W   = 2;
    localparam int DEF_SEQ_LEN = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 16;

    localparam int ST_IDLE = 0;

    // State index needs to reach SEQ_LEN itself, hence SEQ_LEN+1 codes.
    function automatic int st_w_f(input int seq_len);
        return $clog2(seq_len + 1);
    endfunction

    function automatic int st_match_f(input int seq_len);
        return seq_len;
    endfunction

endpackage

// File: rtl/moore_suffix_match.sv
// Combinational longest-suffix/prefix matcher: returns the largest j <= hlen such
// that the newest j history symbols equal pattern symbols 0..j-1.
module moore_suffix_match
    import moore_det_pkg::*;
#(
    parameter int SYM_W   = DEF_SYM_W,
    parameter int SEQ_LEN = DEF_SEQ_LEN,
    parameter int ST_W    = st_w_f(DEF_SEQ_LEN)
) (
    input  logic [SEQ_LEN*SYM_W-1:0] hist,
    input  logic [ST_W-1:0]          hlen,
    input  logic [SEQ_LEN*SYM_W-1:0] pattern,
    output logic [ST_W-1:0]          match_len
);

    logic            ok_s;
    logic [ST_W-1:0] best_s;

    // History slot SEQ_LEN-1 is the newest symbol; try every length, keep the longest hit.
    always_comb begin
        best_s = {ST_W{1'b0}};
        ok_s   = 1'b0;
        for (int j = 1; j <= SEQ_LEN; j++) begin
            ok_s = (ST_W'(j) <= hlen);
            for (int k = 0; k < j; k++) begin
                ok_s = ok_s & (hist[(SEQ_LEN-j+k)*SYM_W +: SYM_W] == pattern[k*SYM_W +: SYM_W]);
            end
            best_s = ok_s ? ST_W'(j) : best_s;
        end
    end

    assign match_len = best_s;

endmodule

// File: rtl/moore_seq_detector.sv
// Programmable Moore sequence detector with overlap mode, clear and saturating match counter.
// Optional inactivity timeout enabled by defining MOORE_DET_TIMEOUT_EN.
module moore_seq_detector
    import moore_det_pkg::*;
#(
    parameter int SYM_W   = DEF_SYM_W,
    parameter int SEQ_LEN = DEF_SEQ_LEN,
    parameter int CNT_W   = DEF_CNT_W
`ifdef MOORE_DET_TIMEOUT_EN
    ,
    parameter int TIMEOUT = DEF_TIMEOUT
`else
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [SYM_W-1:0]              Inp,
    input  logic [SEQ_LEN*SYM_W-1:0]      pattern,
    input  logic                          overlap_en,
    input  logic                          clear,
    output logic [st_w_f(SEQ_LEN)-1:0]    Out_state,
    output logic                          y,
    output logic [CNT_W-1:0]              match_cnt
);

    localparam int              ST_W    = st_w_f(SEQ_LEN);
    localparam int              HIST_W  = SEQ_LEN * SYM_W;
    localparam logic [ST_W-1:0] ST_ZERO = ST_W'(ST_IDLE);
    localparam logic [ST_W-1:0] ST_FULL = ST_W'(st_match_f(SEQ_LEN));
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [ST_W-1:0]   state_r;
    logic              y_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [HIST_W-1:0] hist_r;
    logic [ST_W-1:0]   hlen_r;

    logic              restart_s;
    logic [ST_W-1:0]   base_hlen_s;
    logic [HIST_W-1:0] app_hist_s;
    logic [ST_W-1:0]   app_hlen_s;
    logic [ST_W-1:0]   nxt_state_s;
    logic              tmo_fire_s;

    // Without overlap a completed match empties the history before the next append.
    assign restart_s   = ~overlap_en & (state_r == ST_FULL);
    assign base_hlen_s = restart_s ? ST_ZERO : hlen_r;
    assign app_hist_s  = {Inp, hist_r[HIST_W-1:SYM_W]};
    assign app_hlen_s  = (base_hlen_s == ST_FULL) ? ST_FULL : base_hlen_s + ST_W'(1);

    moore_suffix_match #(
        .SYM_W   (SYM_W),
        .SEQ_LEN (SEQ_LEN),
        .ST_W    (ST_W)
    ) u_match (
        .hist      (app_hist_s),
        .hlen      (app_hlen_s),
        .pattern   (pattern),
        .match_len (nxt_state_s)
    );

`ifdef MOORE_DET_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_r;

    assign tmo_fire_s = ~in_valid & (state_r != ST_ZERO) & (tmo_r == TMO_W'(TIMEOUT - 1));

    // Counts consecutive idle cycles spent away from S0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_r <= {TMO_W{1'b0}};
        end else if (clear || in_valid || (state_r == ST_ZERO) || tmo_fire_s) begin
            tmo_r <= {TMO_W{1'b0}};
        end else begin
            tmo_r <= tmo_r + TMO_W'(1);
        end
    end
`else
    assign tmo_fire_s = 1'b0;
`endif

    // State, history and counter registers; clear outranks a same-cycle symbol.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_ZERO;
            y_r     <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            hist_r  <= {HIST_W{1'b0}};
            hlen_r  <= ST_ZERO;
        end else if (clear || tmo_fire_s) begin
            state_r <= ST_ZERO;
            y_r     <= 1'b0;
            hist_r  <= {HIST_W{1'b0}};
            hlen_r  <= ST_ZERO;
        end else if (in_valid) begin
            state_r <= nxt_state_s;
            y_r     <= (nxt_state_s == ST_FULL);
            hist_r  <= app_hist_s;
            hlen_r  <= app_hlen_s;
            if ((nxt_state_s == ST_FULL) && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign Out_state = state_r;
    assign y         = y_r;
    assign match_cnt = cnt_r;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Scoreboard bench: driver queues hand-computed expectations, a negedge monitor checks them.
module tb_moore_seq_detector;

    localparam int ST_W  = 3;
    localparam int CNT_W = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [1:0] inp;
    logic [7:0] pattern;
    logic       overlap_en;
    logic       clear;
    logic [ST_W-1:0]  out_state;
    logic             y;
    logic [CNT_W-1:0] match_cnt;

    typedef struct {
        string nm;
        int    st;
        int    cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;

    moore_seq_detector #(
        .SYM_W   (2),
        .SEQ_LEN (4),
        .CNT_W   (CNT_W)
`ifdef MOORE_DET_TIMEOUT_EN
        ,
        .TIMEOUT (4)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .Inp        (inp),
        .pattern    (pattern),
        .overlap_en (overlap_en),
        .clear      (clear),
        .Out_state  (out_state),
        .y          (y),
        .match_cnt  (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // Monitor: one expectation per consumed clock edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.nm, ".state"}, int'(out_state), e.st);
            chk({e.nm, ".y"}, int'(y), (e.st == 4) ? 1 : 0);
            chk({e.nm, ".cnt"}, int'(match_cnt), e.cnt);
        end
    end

    task automatic step(input string nm, input logic v, input logic [1:0] s, input logic c,
                        input int est, input int ecnt);
        exp_t x;
        in_valid = v;
        inp      = s;
        clear    = c;
        @(posedge clk);
        x.nm  = nm;
        x.st  = est;
        x.cnt = ecnt;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int st_a[];
        int cnt_a[];
        int seq_a[];
        int cnt0;

        reset = 1'b0; in_valid = 1'b0; inp = 2'd0; clear = 1'b0;
        overlap_en = 1'b1; pattern = 8'b01_01_01_01;
        #20;
        @(negedge clk);
        reset = 1'b1;
        chk("rst.state", int'(out_state), 0);
        chk("rst.y", int'(y), 0);
        chk("rst.cnt", int'(match_cnt), 0);

        // Pattern 1,1,1,1 with overlap.
        st_a  = '{1, 2, 3, 4, 4, 4};
        cnt_a = '{0, 0, 0, 1, 2, 3};
        for (int i = 0; i < 6; i++) step($sformatf("ovl%0d", i), 1'b1, 2'd1, 1'b0, st_a[i], cnt_a[i]);
        step("clr1", 1'b0, 2'd0, 1'b1, 0, 3);

        // Same stimulus, restart after match.
        overlap_en = 1'b0;
        st_a  = '{1, 2, 3, 4, 1, 2};
        cnt_a = '{3, 3, 3, 4, 4, 4};
        for (int i = 0; i < 6; i++) step($sformatf("novl%0d", i), 1'b1, 2'd1, 1'b0, st_a[i], cnt_a[i]);
        step("clr2", 1'b0, 2'd0, 1'b1, 0, 4);

        // Pattern 0,1,0,2 (symbol 0 in the low bits), overlap on.
        overlap_en = 1'b1;
        pattern = {2'd2, 2'd0, 2'd1, 2'd0};
        seq_a = '{0, 1, 0, 1, 0, 2};
        st_a  = '{1, 2, 3, 2, 3, 4};
        cnt_a = '{4, 4, 4, 4, 4, 5};
        for (int i = 0; i < 6; i++) step($sformatf("p0102_%0d", i), 1'b1, 2'(seq_a[i]), 1'b0, st_a[i], cnt_a[i]);
        step("clr3", 1'b0, 2'd0, 1'b1, 0, 5);

        // Same with an idle cycle after every symbol: each state must hold.
        for (int i = 0; i < 6; i++) begin
            cnt0 = (i == 5) ? 6 : 5;
            step($sformatf("gap_v%0d", i), 1'b1, 2'(seq_a[i]), 1'b0, st_a[i], cnt0);
            step($sformatf("gap_h%0d", i), 1'b0, 2'd3, 1'b0, st_a[i], cnt0);
        end
        step("clr4", 1'b0, 2'd0, 1'b1, 0, 6);

        // Clear together with a valid symbol while in S3: symbol must be discarded.
        step("c3_a", 1'b1, 2'd0, 1'b0, 1, 6);
        step("c3_b", 1'b1, 2'd1, 1'b0, 2, 6);
        step("c3_c", 1'b1, 2'd0, 1'b0, 3, 6);
        step("c3_clr", 1'b1, 2'd2, 1'b1, 0, 6);
        step("c3_after", 1'b1, 2'd1, 1'b0, 0, 6);

        // Asynchronous reset mid-sequence.
        step("ar_a", 1'b1, 2'd0, 1'b0, 1, 6);
        step("ar_b", 1'b1, 2'd1, 1'b0, 2, 6);
        step("ar_c", 1'b1, 2'd0, 1'b0, 3, 6);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("arst.state", int'(out_state), 0);
        chk("arst.y", int'(y), 0);
        chk("arst.cnt", int'(match_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        // Reach S2 then go idle for 20 cycles.
        step("to_a", 1'b1, 2'd0, 1'b0, 1, 0);
        step("to_b", 1'b1, 2'd1, 1'b0, 2, 0);
        for (int i = 1; i <= 20; i++) begin
`ifdef MOORE_DET_TIMEOUT_EN
            step($sformatf("idle%0d", i), 1'b0, 2'd0, 1'b0, (i >= 4) ? 0 : 2, 0);
`else
            step($sformatf("idle%0d", i), 1'b0, 2'd0, 1'b0, 2, 0);
`endif
        end
        step("clr5", 1'b0, 2'd0, 1'b1, 0, 0);

        // Counter saturation at 255 with overlapping 1,1,1,1.
        pattern = 8'b01_01_01_01;
        for (int n = 1; n <= 260; n++) begin
            step($sformatf("sat%0d", n), 1'b1, 2'd1, 1'b0, (n < 4) ? n : 4,
                 (n < 4) ? 0 : ((n - 3 > 255) ? 255 : n - 3));
        end
        in_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/moore_seq_detector.md
Name: moore_seq_detector

Overview:
Parametrised Moore-style sequence detector. It recognises a runtime-programmable pattern of SEQ_LEN symbols, each SYM_W bits wide, on a qualified input stream. It is the generalised successor of the fixed 2-bit-input Moore machine: it adds programmable pattern and depth, overlap/non-overlap mode, input qualification, synchronous clear and a saturating match counter. It sits between the input sampling logic and the status/LED logic.

Parameters:
SYM_W, 2, width of one input symbol
SEQ_LEN, 4, pattern length in symbols (≥2)
CNT_W, 8, width of match counter
ST_W, $clog2(SEQ_LEN+1), state encoding width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock, single clock domain
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  Inp qualifier; a symbol is consumed only when in_valid=1
Inp  in  SYM_W  input symbol
pattern  in  SEQ_LEN*SYM_W  target pattern; symbol k at bits [k*SYM_W +: SYM_W]; symbol 0 is matched first
overlap_en  in  1  1 = overlapping detection, 0 = restart after each match
clear  in  1  synchronous flush of history and state
Out_state  out  ST_W  current state index, 0..SEQ_LEN
y  out  1  Moore output; 1 exactly when Out_state==SEQ_LEN
match_cnt  out  CNT_W  number of completed matches, saturating

Behaviour:
- Reset (reset=0, asynchronous): Out_state=0, y=0, match_cnt=0, history cleared. Reset mid-sequence aborts it immediately. First symbol is consumed on the first rising edge after reset deasserts.
- States: S0..S_SEQ_LEN. Sk = the last k consumed symbols equal pattern symbols 0..k-1.
- Internal history: last SEQ_LEN consumed symbols plus a valid-length count hlen (0..SEQ_LEN).
- On an edge with in_valid=1:
  - Append Inp to the history. hlen increments, saturating at SEQ_LEN.
  - Next state = largest j ≤ min(hlen,SEQ_LEN) such that the last j symbols equal pattern[0..j-1]. Pure suffix/prefix match, no KMP table.
  - Registered. Out_state and y update on the same edge that consumes the symbol, giving 1-cycle latency from the symbol to y.
- in_valid=0: state, history, y and match_cnt hold.
- Non-overlap mode (overlap_en=0): when the current state is S_SEQ_LEN, history is treated as empty before the next symbol is appended, so the next state is 1 or 0. Overlap mode keeps history.
- match_cnt: increments by 1 on every edge whose next state is S_SEQ_LEN, including S_SEQ_LEN→S_SEQ_LEN in overlap mode. Saturates at 2^CNT_W-1. clear does not reset it; only reset does.
- clear=1: Out_state=0, y=0, history emptied, regardless of in_valid. clear has priority over a simultaneous symbol, and that symbol is discarded.
- Pattern is quasi-static. Changing it takes effect on the next consumed symbol against the existing history. Software asserts clear after reprogramming.
- y is a decoded register output with no combinational path from Inp.

Optional Feature:
Macro MOORE_DET_TIMEOUT_EN.
- Defined: adds parameter TIMEOUT (default 16). A counter tracks consecutive cycles with in_valid=0 while Out_state≠0. When it reaches TIMEOUT, state and history return to S0/empty on that edge. The counter clears on any in_valid=1, on clear, or on reset.
- Undefined: no counter. State holds indefinitely while in_valid=0.

Decomposition:
- Package moore_det_pkg holds:
  - the ST_W derivation function
  - state constants ST_IDLE=0 and ST_MATCH=SEQ_LEN (as a function of SEQ_LEN)
  - default SYM_W/SEQ_LEN/CNT_W/TIMEOUT
- One sub-module: moore_suffix_match. Combinational; takes history, hlen and pattern, and returns the longest matched prefix length. The top module keeps the registers, counter, modes and timeout.

Test Plan:
- Hold reset=0 for 20 ns with clk running, then release → Out_state=0, y=0, match_cnt=0. Pulse reset=0 while in S3 → Out_state=0 asynchronously, before the next edge.
- Pattern 1,1,1,1, overlap_en=1, Inp=1 with in_valid=1 for 6 cycles → Out_state 1,2,3,4,4,4; y=1 from the 4th edge; match_cnt=3.
- Same stimulus with overlap_en=0 → Out_state 1,2,3,4,1,2; y high one cycle only; match_cnt=1.
- Pattern 0,1,0,2, overlap_en=1, Inp 0,1,0,1,0,2 → Out_state 1,2,3,2,3,4; match_cnt=1. Insert in_valid=0 gaps → identical sequence with holds. Assert clear in S3 together with a valid symbol → Out_state=0 and the symbol is discarded.
- CNT_W=2, pattern 1,1,1,1, overlap on, 8 valid 1s → match_cnt=3 (saturated) with no wrap.
- With MOORE_DET_TIMEOUT_EN and TIMEOUT=4: reach S2, drop in_valid → Out_state=0 on the 4th idle edge. Without the macro → S2 held for 20 idle cycles.
